regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port, built from 32-bit enable/clear registers, between several writeback requesters: ALU, mult/div unit, and the unlock-mechanism I/O capture. Each requester uses a valid/ready handshake. The block picks one requester per cycle by round-robin and drives a registered write port on the next cycle. Writes to register 0 are accepted and then discarded.

Parameters:
N_REQ, 3, number of writeback requesters (2..8)
DATA_W, 32, write data width
ADDR_W, 5, register index width (32 registers)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  N_REQ  requester i has a write pending
req_addr  input  N_REQ*ADDR_W  packed destination indices, requester i at [i*ADDR_W +: ADDR_W]
req_data  input  N_REQ*DATA_W  packed write data, requester i at [i*DATA_W +: DATA_W]
req_ready  output  N_REQ  one-hot-or-zero grant; a handshake completes when valid&ready
ctrl_writeEnable  output  1  register-file write enable, registered
ctrl_writeReg  output  ADDR_W  register-file write index, registered
data_writeReg  output  DATA_W  register-file write data, registered
grant_id  output  3  index of the requester whose write is on the port this cycle, registered
busy  output  1  OR of req_valid, combinational

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-high, named reset. On a clock edge where reset=1, the following values are set:
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, grant_id=0.
  - Round-robin pointer rr_ptr=0.
- req_ready is combinational from req_valid and rr_ptr.
  - While reset=1, req_ready is forced to 0, so no handshake completes.
  - A reset that arrives mid-stream drops the write staged on the port. Requesters must hold valid until they see ready.
- Arbitration: each cycle, search i = rr_ptr, rr_ptr+1, … modulo N_REQ. The first i with req_valid[i]=1 is granted and req_ready[i]=1. All other ready bits are 0. If no requester is valid, req_ready=0.
- Pointer update:
  - On a grant to requester g, rr_ptr ← (g+1) mod N_REQ, wrapping from N_REQ-1 to 0.
  - With no grant, rr_ptr holds.
- Write port latency: exactly 1 cycle.
  - For a handshake in cycle t, the registered outputs in cycle t+1 are ctrl_writeEnable=1, ctrl_writeReg=addr_g, data_writeReg=data_g, grant_id=g.
  - In any cycle with no handshake, the next cycle has ctrl_writeEnable=0. ctrl_writeReg, data_writeReg and grant_id hold their last values.
- Register 0: if addr_g==0, the handshake still completes and rr_ptr still advances. In cycle t+1, ctrl_writeEnable=0 and grant_id=g; ctrl_writeReg and data_writeReg hold.
- Throughput and bounds:
  - One write per cycle; the register file accepts every cycle, so there is no backpressure from the port.
  - Worst-case wait for a continuously valid requester is N_REQ-1 cycles (starvation bound).
- Simultaneous events:
  - Several valid requesters: only one is granted, per the pointer order.
  - Same destination from two requesters: serviced in grant order, and the later grant wins in the register file.
- Inputs sampled only under handshake: req_addr and req_data are sampled only when req_valid&req_ready. Changes while not granted have no effect.
- Width checks: ADDR_W bits index exactly; there is no truncation. grant_id is zero-extended from clog2(N_REQ).

Decomposition:
- Shared package/header `wb_defs`:
  - Constants: REG_ZERO=5'd0, DATA_W=32, ADDR_W=5.
  - Requester index constants: WB_ALU=0, WB_MULTDIV=1, WB_IO=2.
- One sub-module, `rr_pick`: combinational round-robin priority picker.
  - Inputs: valid[N_REQ], ptr.
  - Outputs: onehot grant, encoded index, any.
- The top level holds rr_ptr, the output staging registers and the zero-register filter.

Test Plan:
- Reset then idle: assert reset for 2 cycles with all req_valid=1 -> req_ready=0 during reset; after reset, ctrl_writeEnable=0, rr_ptr=0; first cycle after reset grants requester 0.
- Single requester: req_valid=3'b010, addr=5'd7, data=32'hDEAD_BEEF -> req_ready=3'b010 same cycle; next cycle ctrl_writeEnable=1, ctrl_writeReg=7, data_writeReg=32'hDEADBEEF, grant_id=1.
- All three valid for 6 cycles from reset -> grants 0,1,2,0,1,2; six consecutive write cycles with matching addr/data; no requester waits more than 2 cycles.
- Register-0 drop: requester 2 writes addr=0, data=32'h1234 -> handshake completes; next cycle ctrl_writeEnable=0, grant_id=2; rr_ptr becomes 0.
- Wrap and hold: grant requester 2 (rr_ptr→0), then idle 3 cycles -> rr_ptr stays 0, ctrl_writeEnable=0 and data holds; then valid=3'b110 -> requester 1 granted.
- Reset mid-stream: handshake at cycle t, reset=1 at the t+1 edge -> ctrl_writeEnable=0 after that edge (staged write dropped), rr_ptr=0, no ready while reset is high.

Source files
------------

// File: rtl/wb_defs_pkg.sv
// Shared writeback definitions: widths, the zero register and requester indices.
package wb_defs;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int GRANT_ID_W = 3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Requester slots on the shared writeback port
  localparam int WB_ALU     = 0;
  localparam int WB_MULTDIV = 1;
  localparam int WB_IO      = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr wins.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Scan requesters in rotating order starting from ptr and keep the first valid one
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any && valid[wrap_idx(ptr, k)]) begin
        any                    = 1'b1;
        idx                    = wrap_idx(ptr, k);
        grant[wrap_idx(ptr, k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between writeback requesters.
module regfile_wb_arbiter #(
  parameter int N_REQ  = wb_defs::WB_IO + 1,
  parameter int DATA_W = wb_defs::DATA_W,
  parameter int ADDR_W = wb_defs::ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  import wb_defs::*;

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [N_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_any;
  logic              handshake;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is suppressed during reset so nothing handshakes while the port is being cleared
  always_comb begin
    req_ready = reset ? '0 : pick_grant;
    handshake = pick_any && !reset;
    busy      = |req_valid;
    sel_addr  = req_addr[pick_idx*ADDR_W +: ADDR_W];
    sel_data  = req_data[pick_idx*DATA_W +: DATA_W];
  end

  // Pointer advance, write-port staging and register-0 filtering
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr           <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      grant_id         <= '0;
    end else if (handshake) begin
      rr_ptr   <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      grant_id <= GRANT_ID_W'(pick_idx);
      if (sel_addr != ADDR_W'(REG_ZERO)) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= sel_addr;
        data_writeReg    <= sel_data;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

endmodule
